rom_6502_arbiter: RTL
=====================

# rom_6502_arbiter

Shares the single-port 4 KB 6502 program ROM between two read requesters: the PIF 6502 core's fetch port (CPU) and an auxiliary reader (AUX: boot-copy/checksum engine). It grants one requester at a time and drives the ROM's address/output-enable pair. It captures the registered ROM data on the ROM's valid strobe and returns it with a one-cycle acknowledge. A watchdog completes any read whose valid never arrives.

## Interface
- TIMEOUT_CYCLES, 15: WAIT-state cycles before a read is force-completed (1..255).
- STARVE_LIMIT, 4: consecutive AUX losses before AUX is force-granted (only with fairness macro; 1..15).

- clk  in  1  single system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high.
- cpu_req  in  1  CPU read request, level, held until cpu_ack.
- cpu_addr  in  12  CPU byte address, sampled at grant.
- cpu_ack  out  1  one-cycle pulse: cpu_rdata valid.
- cpu_rdata  out  8  CPU read data, held until next cpu_ack.
- aux_req  in  1  AUX read request, level, held until aux_ack.
- aux_addr  in  12  AUX byte address, sampled at grant.
- aux_ack  out  1  one-cycle pulse: aux_rdata valid.
- aux_rdata  out  8  AUX read data, held until next aux_ack.
- rom_address  out  12  to ROM address_a.
- rom_oe  out  1  to ROM oe; one-cycle pulse per read.
- rom_valid  in  1  from ROM valid (oe delayed one clock).
- rom_q  in  8  from ROM q_a.
- timeout_err  out  1  one-cycle pulse alongside an ack whose read timed out.

## Operation
- All outputs are registered. Reset values: every output 0, state IDLE, owner CPU, counters 0.
- States:
  - IDLE: if cpu_req or aux_req is high, pick winner, latch owner, rom_address <= winner addr, rom_oe <= 1, go to ISSUE. Otherwise stay; rom_valid is ignored in IDLE.
  - ISSUE: rom_oe <= 0, clear timeout counter, go to WAIT.
  - WAIT: if rom_valid, owner rdata <= rom_q, owner ack <= 1, go to RESP. Otherwise, if counter == TIMEOUT_CYCLES-1, owner rdata <= 8'hFF, owner ack <= 1, timeout_err <= 1, go to RESP. Otherwise increment the counter.
  - RESP: clear acks and timeout_err, go to IDLE. Requests are ignored in RESP.
- Arbitration (default): fixed priority; CPU wins any simultaneous request.
- Requester rule: deassert req on the clock edge where ack is high unless another read is wanted. A req still high in IDLE starts a new read with the current addr.
- Address or req changes after grant do not affect the in-flight read.
- Only the owner's ack and rdata change; the other port's rdata holds.
- rom_address holds its last value between reads.

## Timing
- Req high before edge E0 (IDLE). Then: rom_oe high E0–E1; ROM samples at E1; rom_valid high E1–E2; capture at E2; ack high E2–E3; IDLE after E3.
- Ack is the 3rd cycle after the request edge. Back-to-back throughput is 1 read per 4 cycles.
- Timeout path: ack at E1 + TIMEOUT_CYCLES.
- Reset asserted mid-read: immediate return to IDLE with all outputs 0. No ack is issued for the aborted read, and a stale rom_valid after reset release is ignored.

## Configuration
- ROM6502_ARB_FAIRNESS_EN defined: a 4-bit starve counter tracks AUX losses.
  - Each IDLE grant to CPU while aux_req is high increments the counter (saturating).
  - When the counter is ≥ STARVE_LIMIT, AUX wins the next simultaneous request.
  - The counter clears on an AUX grant or when aux_req is low in IDLE.
- Not defined: strict CPU priority; AUX can starve indefinitely; no counter logic.

## Test plan
- Single CPU read, ROM model mem[0x123]=0xA5, cpu_addr=0x123 -> rom_oe pulse one cycle with rom_address=0x123; cpu_ack 3 cycles after request edge; cpu_rdata=0xA5; aux_ack stays 0.
- Simultaneous cpu_req (0x010) and aux_req (0x020), mem = address low byte -> CPU served first (0x10), AUX next grant (0x20), 4-cycle spacing.
- ROM model never asserts valid, TIMEOUT_CYCLES=15 -> cpu_ack with cpu_rdata=0xFF and timeout_err pulse together at E1+15.
- Reset asserted in WAIT, then valid arrives after release -> no ack, all outputs 0, next request served normally.
- Fairness defined, STARVE_LIMIT=4, cpu_req and aux_req held high continuously -> 4 CPU grants, then 1 AUX grant, repeating. Fairness undefined -> AUX never granted while cpu_req is high.
- Address changed during WAIT -> returned data matches the address latched at grant.

Source files
------------

// File: rtl/rom_6502_arbiter.sv
// Two-requester read arbiter for the shared 4 KB 6502 program ROM (CPU fetch vs. AUX reader).
// Define ROM6502_ARB_FAIRNESS_EN to force an AUX grant after STARVE_LIMIT consecutive losses.
module rom_6502_arbiter #(
    parameter int TIMEOUT_CYCLES = 15
`ifdef ROM6502_ARB_FAIRNESS_EN
    , parameter int STARVE_LIMIT = 4
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [11:0] cpu_addr,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    input  logic        aux_req,
    input  logic [11:0] aux_addr,
    output logic        aux_ack,
    output logic [7:0]  aux_rdata,
    output logic [11:0] rom_address,
    output logic        rom_oe,
    input  logic        rom_valid,
    input  logic [7:0]  rom_q,
    output logic        timeout_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

    state_t      state, state_next;
    logic        owner_aux, owner_aux_next;
    logic [7:0]  timeout_cnt, timeout_cnt_next;
    logic [11:0] rom_address_next;
    logic        rom_oe_next;
    logic        cpu_ack_next, aux_ack_next, timeout_err_next;
    logic [7:0]  cpu_rdata_next, aux_rdata_next;
    logic        aux_wins;
    logic        any_req;

`ifdef ROM6502_ARB_FAIRNESS_EN
    logic [3:0]  starve_cnt, starve_cnt_next;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            owner_aux   <= 1'b0;
            timeout_cnt <= 8'd0;
            rom_address <= 12'd0;
            rom_oe      <= 1'b0;
            cpu_ack     <= 1'b0;
            cpu_rdata   <= 8'd0;
            aux_ack     <= 1'b0;
            aux_rdata   <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            owner_aux   <= owner_aux_next;
            timeout_cnt <= timeout_cnt_next;
            rom_address <= rom_address_next;
            rom_oe      <= rom_oe_next;
            cpu_ack     <= cpu_ack_next;
            cpu_rdata   <= cpu_rdata_next;
            aux_ack     <= aux_ack_next;
            aux_rdata   <= aux_rdata_next;
            timeout_err <= timeout_err_next;
        end
    end

`ifdef ROM6502_ARB_FAIRNESS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) starve_cnt <= 4'd0;
        else       starve_cnt <= starve_cnt_next;
    end

    // AUX takes a contested grant once it has lost STARVE_LIMIT times in a row
    always_comb begin
        aux_wins        = aux_req && (!cpu_req || (starve_cnt >= 4'(STARVE_LIMIT)));
        starve_cnt_next = starve_cnt;
        if (state == ST_IDLE) begin
            if (!aux_req || aux_wins)
                starve_cnt_next = 4'd0;
            else if (cpu_req && (starve_cnt != 4'hF))
                starve_cnt_next = starve_cnt + 4'd1;
        end
    end
`else
    always_comb begin
        aux_wins = aux_req && !cpu_req;
    end
`endif

    assign any_req = cpu_req || aux_req;

    always_comb begin
        state_next       = state;
        owner_aux_next   = owner_aux;
        timeout_cnt_next = timeout_cnt;
        rom_address_next = rom_address;
        rom_oe_next      = 1'b0;
        cpu_ack_next     = 1'b0;
        aux_ack_next     = 1'b0;
        timeout_err_next = 1'b0;
        cpu_rdata_next   = cpu_rdata;
        aux_rdata_next   = aux_rdata;

        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    owner_aux_next   = aux_wins;
                    rom_address_next = aux_wins ? aux_addr : cpu_addr;
                    rom_oe_next      = 1'b1;
                    state_next       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                timeout_cnt_next = 8'd0;
                state_next       = ST_WAIT;
            end
            ST_WAIT: begin
                // A missing valid strobe is completed with 0xFF and flagged
                if (rom_valid || (timeout_cnt == 8'(TIMEOUT_CYCLES - 1))) begin
                    timeout_err_next = !rom_valid;
                    if (owner_aux) begin
                        aux_ack_next   = 1'b1;
                        aux_rdata_next = rom_valid ? rom_q : 8'hFF;
                    end else begin
                        cpu_ack_next   = 1'b1;
                        cpu_rdata_next = rom_valid ? rom_q : 8'hFF;
                    end
                    state_next = ST_RESP;
                end else begin
                    timeout_cnt_next = timeout_cnt + 8'd1;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule
